// File: rtl/capture_compare_channel.sv
// capture_compare_channel: one timer capture/compare channel (output compare and input capture).
// Optional feature macro CC_DMA_REQ_EN: dma_req_o pulses for one cycle on every CCxIF set event.
module capture_compare_channel #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 aresetn_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 dir_i,
    input  logic                 uev_i,
    input  logic [1:0]           ccs_i,
    input  logic [2:0]           ocm_i,
    input  logic                 ocpe_i,
    input  logic                 ccp_i,
    input  logic                 cce_i,
    input  logic [3:0]           icf_i,
    input  logic [1:0]           icpsc_i,
    input  logic                 ti_i,
    input  logic [CNT_WIDTH-1:0] ccr_i,
    input  logic                 ccr_wr_i,
    input  logic                 ccif_clr_i,
    output logic [CNT_WIDTH-1:0] ccr_o,
    output logic                 ccif_o,
    output logic                 ccof_o,
    output logic                 oc_ref_o,
    output logic                 oc_o,
    output logic                 dma_req_o
);

    typedef enum logic [2:0] {
        OcmFrozen   = 3'b000,
        OcmSetMatch = 3'b001,
        OcmClrMatch = 3'b010,
        OcmToggle   = 3'b011,
        OcmForceLo  = 3'b100,
        OcmForceHi  = 3'b101,
        OcmPwm1     = 3'b110,
        OcmPwm2     = 3'b111
    } ocm_e;

    logic [CNT_WIDTH-1:0] ccr_q, ccr_d;
    logic [CNT_WIDTH-1:0] preload_q, preload_d;
    logic                 ccif_q, ccif_d;
    logic                 ccof_q, ccof_d;
    logic                 oc_ref_q, oc_ref_d;
    logic                 match_q;
    logic                 ti_s1_q, ti_s2_q;
    logic                 filt_q, filt_d;
    logic [3:0]           flt_cnt_q, flt_cnt_d;
    logic                 lvl_prev_q;
    logic [2:0]           psc_cnt_q, psc_cnt_d;
    logic [1:0]           ccs_q;
    logic [1:0]           icpsc_q;

    logic       oc_mode, ic_mode, cfg_chg;
    logic       match, pwm1_ref, oc_set;
    logic       flt_level, edge_det, capture, set_ev;
    logic [4:0] flt_cnt_inc;
    logic [2:0] psc_max;
    ocm_e       ocm;

    assign oc_mode = (ccs_i == 2'b00);
    assign ic_mode = (ccs_i == 2'b01);
    // Mode or prescaler reprogramming restarts edge counting and filtering from scratch.
    assign cfg_chg = (ccs_i != ccs_q) || (icpsc_i != icpsc_q);
    assign ocm     = ocm_e'(ocm_i);

    // ---------------- Output compare ----------------
    assign match    = (cnt_i == ccr_q);
    assign pwm1_ref = dir_i ? (cnt_i <= ccr_q) : (cnt_i < ccr_q);
    assign oc_set   = oc_mode && match && !match_q;

    always_comb begin
        oc_ref_d = oc_ref_q;
        if (oc_mode) begin
            case (ocm)
                OcmSetMatch: if (match) oc_ref_d = 1'b1;
                OcmClrMatch: if (match) oc_ref_d = 1'b0;
                OcmToggle:   if (match) oc_ref_d = !oc_ref_q;
                OcmForceLo:  oc_ref_d = 1'b0;
                OcmForceHi:  oc_ref_d = 1'b1;
                OcmPwm1:     oc_ref_d = pwm1_ref;
                OcmPwm2:     oc_ref_d = !pwm1_ref;
                default:     oc_ref_d = oc_ref_q;
            endcase
        end
    end

    // ---------------- Input capture ----------------
    assign flt_level   = (icf_i == 4'd0) ? ti_s2_q : filt_q;
    assign flt_cnt_inc = {1'b0, flt_cnt_q} + 5'd1;
    assign edge_det    = ccp_i ? (!flt_level && lvl_prev_q) : (flt_level && !lvl_prev_q);

    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = flt_cnt_q;
        if (icf_i == 4'd0) begin
            // Track the synchronizer so enabling the filter later starts from the true level.
            filt_d    = ti_s2_q;
            flt_cnt_d = 4'd0;
        end else if (ti_s2_q != filt_q) begin
            if (flt_cnt_inc >= {1'b0, icf_i}) begin
                filt_d    = ti_s2_q;
                flt_cnt_d = 4'd0;
            end else begin
                flt_cnt_d = flt_cnt_inc[3:0];
            end
        end else begin
            flt_cnt_d = 4'd0;
        end
        if (cfg_chg) flt_cnt_d = 4'd0;
    end

    always_comb begin
        case (icpsc_i)
            2'd0:    psc_max = 3'd0;
            2'd1:    psc_max = 3'd1;
            2'd2:    psc_max = 3'd3;
            default: psc_max = 3'd7;
        endcase
    end

    assign capture = ic_mode && edge_det && !cfg_chg && (psc_cnt_q == psc_max);

    always_comb begin
        psc_cnt_d = psc_cnt_q;
        if (cfg_chg) begin
            psc_cnt_d = 3'd0;
        end else if (ic_mode && edge_det) begin
            psc_cnt_d = capture ? 3'd0 : psc_cnt_q + 3'd1;
        end
    end

    // ---------------- CCR and flags ----------------
    always_comb begin
        ccr_d     = ccr_q;
        preload_d = preload_q;
        if (oc_mode) begin
            if (ocpe_i) begin
                // A same-cycle write lands in preload; the update takes the old preload value.
                if (uev_i)    ccr_d     = preload_q;
                if (ccr_wr_i) preload_d = ccr_i;
            end else if (ccr_wr_i) begin
                ccr_d = ccr_i;
            end
        end
        if (capture) ccr_d = cnt_i;
    end

    assign set_ev = oc_set || capture;

    always_comb begin
        ccif_d = ccif_q;
        ccof_d = ccof_q;
        if (set_ev) begin
            ccif_d = 1'b1;
        end else if (ccif_clr_i) begin
            ccif_d = 1'b0;
        end
        if (capture && ccif_q) begin
            ccof_d = 1'b1;
        end else if (ccif_clr_i && !capture) begin
            ccof_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            ccr_q      <= '0;
            preload_q  <= '0;
            ccif_q     <= 1'b0;
            ccof_q     <= 1'b0;
            oc_ref_q   <= 1'b0;
            match_q    <= 1'b0;
            ti_s1_q    <= 1'b0;
            ti_s2_q    <= 1'b0;
            filt_q     <= 1'b0;
            flt_cnt_q  <= 4'd0;
            lvl_prev_q <= 1'b0;
            psc_cnt_q  <= 3'd0;
            ccs_q      <= 2'b00;
            icpsc_q    <= 2'b00;
        end else begin
            ccr_q      <= ccr_d;
            preload_q  <= preload_d;
            ccif_q     <= ccif_d;
            ccof_q     <= ccof_d;
            oc_ref_q   <= oc_ref_d;
            match_q    <= oc_mode && match;
            ti_s1_q    <= ti_i;
            ti_s2_q    <= ti_s1_q;
            filt_q     <= filt_d;
            flt_cnt_q  <= flt_cnt_d;
            lvl_prev_q <= flt_level;
            psc_cnt_q  <= psc_cnt_d;
            ccs_q      <= ccs_i;
            icpsc_q    <= icpsc_i;
        end
    end

`ifdef CC_DMA_REQ_EN
    logic dma_q;

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            dma_q <= 1'b0;
        end else begin
            dma_q <= set_ev;
        end
    end

    assign dma_req_o = dma_q;
`else
    assign dma_req_o = 1'b0;
`endif

    assign ccr_o    = ccr_q;
    assign ccif_o   = ccif_q;
    assign ccof_o   = ccof_q;
    assign oc_ref_o = oc_ref_q;
    assign oc_o     = cce_i ? (oc_ref_q ^ ccp_i) : 1'b0;

endmodule

// File: tb/tb_capture_compare_channel.sv
// Self-checking bench for capture_compare_channel: directed scenarios plus randomized OC/IC runs
// against a behavioural model.
module tb_capture_compare_channel;

`ifdef CC_DMA_REQ_EN
    localparam bit DmaEn = 1'b1;
`else
    localparam bit DmaEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] cnt;
    logic        dir, uev, ocpe, ccp, cce, ti, wr, clr;
    logic [1:0]  ccs, icpsc;
    logic [2:0]  ocm;
    logic [3:0]  icf;
    logic [31:0] wdata;
    logic [31:0] ccr;
    logic        ccif, ccof, oc_ref, oc_o, dma;

    int n_checks = 0;
    int n_pass   = 0;
    bit cnt_auto = 1'b0;

    capture_compare_channel #(.CNT_WIDTH(32)) dut (
        .clk_i      (clk),
        .aresetn_i  (aresetn),
        .cnt_i      (cnt),
        .dir_i      (dir),
        .uev_i      (uev),
        .ccs_i      (ccs),
        .ocm_i      (ocm),
        .ocpe_i     (ocpe),
        .ccp_i      (ccp),
        .cce_i      (cce),
        .icf_i      (icf),
        .icpsc_i    (icpsc),
        .ti_i       (ti),
        .ccr_i      (wdata),
        .ccr_wr_i   (wr),
        .ccif_clr_i (clr),
        .ccr_o      (ccr),
        .ccif_o     (ccif),
        .ccof_o     (ccof),
        .oc_ref_o   (oc_ref),
        .oc_o       (oc_o),
        .dma_req_o  (dma)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (cnt_auto) cnt = cnt + 32'd1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; cnt = '0; dir = 0; uev = 0; ocpe = 0; ccp = 0; cce = 0; ti = 0;
        wr = 0; clr = 0; ccs = 2'b00; icpsc = 0; ocm = 0; icf = 0; wdata = '0;
        repeat (2) tick();
        if (ccr !== 32'd0) $display("FAIL reset_ccr: got %0h expected 0", ccr);
        else n_pass++;
        n_checks++;
        if ({ccif, ccof, oc_ref, oc_o, dma} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {ccif, ccof, oc_ref, oc_o, dma});
        else n_pass++;
        n_checks++;
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_pwm1();
        int c;
        logic e_ref, e_if, e_dma;
        cnt_auto = 0; ccs = 2'b00; ocpe = 0; cce = 1; ccp = 0; clr = 1; ocm = 3'b110; dir = 0;
        cnt = 32'd9; wdata = 32'd3; wr = 1;
        tick();
        wr = 0;
        for (int i = 0; i < 20; i++) begin
            c = i % 10;
            cnt = 32'(c);
            tick();
            e_ref = (c < 3);
            e_if  = (c == 3);
            e_dma = DmaEn && e_if;
            if (oc_ref !== e_ref) $display("FAIL pwm1_ref cnt=%0d: got %b expected %b", c, oc_ref, e_ref);
            else n_pass++;
            n_checks++;
            if (ccif !== e_if) $display("FAIL pwm1_ccif cnt=%0d: got %b expected %b", c, ccif, e_if);
            else n_pass++;
            n_checks++;
            if (dma !== e_dma) $display("FAIL pwm1_dma cnt=%0d: got %b expected %b", c, dma, e_dma);
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_preload();
        logic [31:0] exp_seq [5] = '{32'd3, 32'd3, 32'd5, 32'd5, 32'd7};
        cnt_auto = 0; ccs = 2'b00; ocm = 3'b000; clr = 1; cnt = 32'd1000;
        ocpe = 0; wdata = 32'd3; wr = 1;
        tick();
        for (int s = 0; s < 5; s++) begin
            ocpe = 1; wr = 0; uev = 0;
            case (s)
                0: begin wr = 1; wdata = 32'd5; end
                1: ;
                2: uev = 1;
                3: begin wr = 1; wdata = 32'd7; uev = 1; end
                default: uev = 1;
            endcase
            tick();
            if (ccr !== exp_seq[s]) $display("FAIL preload_step%0d: got %0d expected %0d", s, ccr, exp_seq[s]);
            else n_pass++;
            n_checks++;
        end
        wr = 0; uev = 0; ocpe = 0;
    endtask

    task automatic test_toggle();
        int c;
        logic mref, e_oc;
        cnt_auto = 0; ccs = 2'b00; clr = 1; ocpe = 0; ocm = 3'b100; cnt = 32'd7;
        wdata = 32'd2; wr = 1; cce = 1; ccp = 0;
        tick();
        wr = 0; ocm = 3'b011; mref = 0;
        for (int i = 0; i < 40; i++) begin
            c = i % 8;
            cce = !(i >= 16 && i < 24);
            ccp = (i >= 24);
            cnt = 32'(c);
            tick();
            if (c == 2) mref = !mref;
            e_oc = cce ? (mref ^ ccp) : 1'b0;
            if (oc_ref !== mref) $display("FAIL toggle_ref i=%0d: got %b expected %b", i, oc_ref, mref);
            else n_pass++;
            n_checks++;
            if (oc_o !== e_oc) $display("FAIL toggle_oc i=%0d: got %b expected %b", i, oc_o, e_oc);
            else n_pass++;
            n_checks++;
        end
        cce = 0; ccp = 0;
    endtask

    task automatic test_ic_basic();
        logic [31:0] v;
        ccs = 2'b01; icf = 0; icpsc = 0; ccp = 0; ti = 0; clr = 1;
        cnt_auto = 1; cnt = 32'd90;
        repeat (3) tick();
        clr = 0;
        cnt = 32'd100; ti = 1;
        tick();
        tick();
        if (ccif !== 1'b0) $display("FAIL ic_early_ccif: got %b expected 0", ccif);
        else n_pass++;
        n_checks++;
        tick();
        if (ccr !== 32'd102) $display("FAIL ic_ccr: got %0d expected 102", ccr);
        else n_pass++;
        n_checks++;
        if ({ccif, ccof} !== 2'b10) $display("FAIL ic_flags: got %b expected 10", {ccif, ccof});
        else n_pass++;
        n_checks++;
        // second edge without a clear -> overcapture
        ti = 0; repeat (3) tick();
        v = cnt; ti = 1; repeat (3) tick();
        if (ccr !== v + 32'd2) $display("FAIL ic_ccr2: got %0d expected %0d", ccr, v + 32'd2);
        else n_pass++;
        n_checks++;
        if ({ccif, ccof} !== 2'b11) $display("FAIL ic_overcapture: got %b expected 11", {ccif, ccof});
        else n_pass++;
        n_checks++;
        clr = 1; tick(); clr = 0;
        if ({ccif, ccof} !== 2'b00) $display("FAIL ic_clear: got %b expected 00", {ccif, ccof});
        else n_pass++;
        n_checks++;
        // clear arriving with a capture loses to the capture
        for (int k = 0; k < 2; k++) begin
            ti = 0; repeat (3) tick();
            v = cnt; ti = 1; tick(); tick();
            clr = 1; tick(); clr = 0;
            if ({ccif, ccof} !== {1'b1, k == 1})
                $display("FAIL ic_clr_vs_cap%0d: got %b expected %b", k, {ccif, ccof}, {1'b1, k == 1});
            else n_pass++;
            n_checks++;
            if (ccr !== v + 32'd2) $display("FAIL ic_clr_ccr%0d: got %0d expected %0d", k, ccr, v + 32'd2);
            else n_pass++;
            n_checks++;
            if (dma !== DmaEn) $display("FAIL ic_dma%0d: got %b expected %b", k, dma, DmaEn);
            else n_pass++;
            n_checks++;
            tick();
            if (dma !== 1'b0) $display("FAIL ic_dma_pulse%0d: got %b expected 0", k, dma);
            else n_pass++;
            n_checks++;
        end
        ti = 0; clr = 1; repeat (3) tick(); clr = 0;
    endtask

    task automatic test_ic_filter();
        logic [31:0] v;
        ccs = 2'b01; icf = 4'd4; icpsc = 0; ccp = 0; ti = 0; clr = 1; cnt_auto = 1;
        repeat (10) tick();
        clr = 0;
        ti = 1; repeat (3) tick();
        ti = 0; repeat (10) tick();
        if (ccif !== 1'b0) $display("FAIL filt_glitch: got %b expected 0", ccif);
        else n_pass++;
        n_checks++;
        v = cnt;
        ti = 1; repeat (4) tick();
        ti = 0; repeat (10) tick();
        if ({ccif, ccof} !== 2'b10) $display("FAIL filt_pulse_flags: got %b expected 10", {ccif, ccof});
        else n_pass++;
        n_checks++;
        if (ccr !== v + 32'd6) $display("FAIL filt_pulse_ccr: got %0d expected %0d", ccr, v + 32'd6);
        else n_pass++;
        n_checks++;
        // capture only on every 4th edge
        icf = 0; icpsc = 2'd2; clr = 1;
        repeat (5) tick();
        clr = 0;
        repeat (3) begin
            ti = 1; repeat (2) tick();
            ti = 0; repeat (3) tick();
        end
        if (ccif !== 1'b0) $display("FAIL psc_early: got %b expected 0", ccif);
        else n_pass++;
        n_checks++;
        v = cnt;
        ti = 1; repeat (2) tick();
        ti = 0; repeat (3) tick();
        if (ccif !== 1'b1) $display("FAIL psc_fourth: got %b expected 1", ccif);
        else n_pass++;
        n_checks++;
        if (ccr !== v + 32'd2) $display("FAIL psc_ccr: got %0d expected %0d", ccr, v + 32'd2);
        else n_pass++;
        n_checks++;
        icpsc = 0;
    endtask

    task automatic test_idle_and_async_reset();
        cnt_auto = 0; ccs = 2'b00; ocpe = 0; ocm = 3'b101; cnt = 32'd5;
        wdata = 32'd50; wr = 1; clr = 1; cce = 1; ccp = 0;
        tick();
        wr = 0;
        tick();
        if (oc_ref !== 1'b1) $display("FAIL force_hi: got %b expected 1", oc_ref);
        else n_pass++;
        n_checks++;
        ccs = 2'b10; ocm = 3'b100; clr = 0; cnt = 32'd50;
        repeat (3) tick();
        if ({oc_ref, ccif} !== 2'b10) $display("FAIL idle_hold: got %b expected 10", {oc_ref, ccif});
        else n_pass++;
        n_checks++;
        if (ccr !== 32'd50) $display("FAIL idle_ccr: got %0d expected 50", ccr);
        else n_pass++;
        n_checks++;
        // mid-PWM reset: flags and outputs drop without waiting for a clock
        ccs = 2'b00; ocm = 3'b110; cnt = 32'd49; tick();
        cnt = 32'd50; tick();
        #2;
        aresetn = 1'b0;
        #1;
        if ({ccr != 32'd0, ccif, ccof, oc_ref, oc_o, dma} !== 6'b0)
            $display("FAIL async_reset: got %b expected 000000", {ccr != 32'd0, ccif, ccof, oc_ref, oc_o, dma});
        else n_pass++;
        n_checks++;
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_random_oc();
        int p, cval, d, mode, c;
        logic mref, mprev, match, pwm1, e_if, e_oc;
        for (int r = 0; r < 12; r++) begin
            p = $urandom_range(4, 12);
            cval = $urandom_range(0, p + 1);
            d = $urandom_range(0, 1);
            mode = $urandom_range(0, 7);
            cnt_auto = 0; ccs = 2'b00; ocpe = 0; clr = 1; uev = 0;
            cce = 1'($urandom_range(0, 1)); ccp = 1'($urandom_range(0, 1)); dir = 1'(d);
            ocm = 3'b100; wdata = 32'(cval); wr = 1; cnt = 32'(p + 5);
            tick();
            wr = 0;
            c = d ? p - 1 : 0;
            cnt = 32'(c);
            tick();
            mref = 0;
            mprev = (c == cval);
            ocm = 3'(mode);
            for (int i = 1; i <= 30; i++) begin
                c = d ? (p - 1 - (i % p)) : (i % p);
                cnt = 32'(c);
                tick();
                match = (c == cval);
                pwm1 = d ? (c <= cval) : (c < cval);
                case (mode)
                    0: ;
                    1: if (match) mref = 1;
                    2: if (match) mref = 0;
                    3: if (match) mref = !mref;
                    4: mref = 0;
                    5: mref = 1;
                    6: mref = pwm1;
                    default: mref = !pwm1;
                endcase
                e_if = match && !mprev;
                mprev = match;
                e_oc = cce ? (mref ^ ccp) : 1'b0;
                if (oc_ref !== mref)
                    $display("FAIL roc_ref r=%0d i=%0d mode=%0d: got %b expected %b", r, i, mode, oc_ref, mref);
                else n_pass++;
                n_checks++;
                if (ccif !== e_if) $display("FAIL roc_ccif r=%0d i=%0d: got %b expected %b", r, i, ccif, e_if);
                else n_pass++;
                n_checks++;
                if (oc_o !== e_oc) $display("FAIL roc_oc r=%0d i=%0d: got %b expected %b", r, i, oc_o, e_oc);
                else n_pass++;
                n_checks++;
                if (dma !== (DmaEn && e_if))
                    $display("FAIL roc_dma r=%0d i=%0d: got %b expected %b", r, i, dma, DmaEn && e_if);
                else n_pass++;
                n_checks++;
            end
        end
        dir = 0; cce = 0; ccp = 0;
    endtask

    task automatic test_random_ic();
        int nf, ps, pol, t, len, nrise, dly;
        int nf_tab [5] = '{0, 1, 2, 3, 5};
        bit x [80];
        bit cap [90];
        bit v, f, ft, ok;
        logic [31:0] base, e_ccr;
        logic e_if, e_of, e_dma;
        cnt_auto = 0; ccs = 2'b00; ocpe = 0; wdata = 32'd0; wr = 1;
        tick();
        wr = 0;
        e_ccr = 32'd0;
        for (int r = 0; r < 10; r++) begin
            nf = nf_tab[$urandom_range(0, 4)];
            ps = $urandom_range(0, 3);
            pol = $urandom_range(0, 1);
            ccs = 2'b10; ti = 0; clr = 1;
            tick(); tick();
            ccs = 2'b01; icf = 4'(nf); icpsc = 2'(ps); ccp = 1'(pol);
            repeat (20) tick();
            clr = 0; e_if = 0; e_of = 0;
            t = 0; v = 1;
            while (t < 60) begin
                len = $urandom_range(1, 6);
                for (int j = 0; j < len && t < 60; j++) begin x[t] = v; t++; end
                v = !v;
            end
            for (int j = 60; j < 80; j++) x[j] = 0;
            foreach (cap[j]) cap[j] = 0;
            f = 0; nrise = 0;
            dly = (nf == 0) ? 2 : 3;
            for (int j = 0; j < 80; j++) begin
                if (nf == 0) begin
                    ft = x[j];
                end else begin
                    ft = f;
                    if (j >= nf - 1) begin
                        ok = 1;
                        for (int k = 0; k < nf; k++) if (x[j - k] == f) ok = 0;
                        if (ok) ft = !f;
                    end
                end
                if (ft != f && ft != 1'(pol)) begin
                    if ((nrise % (1 << ps)) == (1 << ps) - 1) cap[j + dly] = 1;
                    nrise++;
                end
                f = ft;
            end
            base = 32'($urandom_range(0, 100000));
            for (int j = 0; j < 80; j++) begin
                ti = x[j];
                cnt = base + 32'(j);
                tick();
                e_dma = 0;
                if (cap[j]) begin
                    e_of = e_of | e_if;
                    e_if = 1;
                    e_ccr = base + 32'(j);
                    e_dma = DmaEn;
                end
                if (ccr !== e_ccr) $display("FAIL ric_ccr r=%0d t=%0d: got %0d expected %0d", r, j, ccr, e_ccr);
                else n_pass++;
                n_checks++;
                if ({ccif, ccof} !== {e_if, e_of})
                    $display("FAIL ric_flags r=%0d t=%0d: got %b expected %b", r, j, {ccif, ccof}, {e_if, e_of});
                else n_pass++;
                n_checks++;
                if (dma !== e_dma) $display("FAIL ric_dma r=%0d t=%0d: got %b expected %b", r, j, dma, e_dma);
                else n_pass++;
                n_checks++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_pwm1();
        test_preload();
        test_toggle();
        test_ic_basic();
        test_ic_filter();
        test_idle_and_async_reset();
        test_random_oc();
        test_random_ic();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
